// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
//
// Shared constants for the 1x3 router datapath.
//
// Contents:
//   WIDTH, DEPTH, ADDR_W, CNT_W  default FIFO geometry
//   LEN_*, DEST_*                header byte field positions
//   IDLE_DATA                    value driven on data_out between packets
//   header_count()               bytes still to come after a header
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 7;

    // Header byte layout: [7:2] payload length, [1:0] destination port.
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int DEST_MSB = 1;
    localparam int DEST_LSB = 0;

    localparam logic [WIDTH-1:0] IDLE_DATA = '0;

    // After the header leaves the FIFO, the payload plus one parity byte
    // still have to be read.  A zero-length packet therefore yields 1.
    function automatic logic [CNT_W-1:0] header_count(
        input logic [LEN_MSB-LEN_LSB:0] len
    );
        return CNT_W'(len) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// ---------------------------------------------------------------------------
// router_fifo_mem
//
// Storage array for router_fifo: DEPTH entries of WIDTH+1 bits (data plus
// header flag).  Synchronous write, registered read, no reset, so it can be
// swapped for a RAM macro without touching the control logic.
//
// Ports:
//   clock    in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   {header_flag, data}
//   rd_en    in   read strobe; rd_data updates only when set
//   rd_addr  in   read index
//   rd_data  out  registered read entry
// ---------------------------------------------------------------------------
module router_fifo_mem #(
    parameter int WIDTH  = router_pkg::WIDTH,
    parameter int DEPTH  = router_pkg::DEPTH,
    parameter int ADDR_W = router_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH:0]    wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH:0]    rd_data
);

    logic [WIDTH:0] mem [DEPTH];

    // The controller never reads and writes the same index in one cycle
    // (that would need the FIFO to be both empty and full), so no
    // read-during-write bypass is needed here.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo
//
// Per-destination output FIFO of the 1x3 router.  Buffers bytes from the
// register stage, tags packet headers, and presents bytes to the destination
// reader with one cycle of read latency.  data_out returns to the idle value
// once the parity byte of the current packet has been read.
//
// Ports:
//   clock       in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   soft_reset  in   synchronous flush (synchroniser timeout), active-high
//   write_enb   in   write request
//   lfd_state   in   current write is a header byte
//   data_in     in   byte to store
//   read_enb    in   read request
//   data_out    out  read data, valid the cycle after an accepted read
//   full        out  DEPTH entries held
//   empty       out  no entries held
// ---------------------------------------------------------------------------
module router_fifo #(
    parameter int WIDTH  = router_pkg::WIDTH,
    parameter int DEPTH  = router_pkg::DEPTH,
    parameter int ADDR_W = router_pkg::ADDR_W,
    parameter int CNT_W  = router_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    import router_pkg::*;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;

    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH:0]   rd_q;

    // count_q is the packet counter as of the previous edge's update; the
    // entry read at that edge only becomes visible in rd_q afterwards, so
    // count_cur folds that pending read in to give the up-to-date value.
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_cur;
    logic             rd_pending;

    // When clear, data_out shows the idle value instead of rd_q.
    logic             show_data;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // Flags are evaluated on pre-edge pointers, which gives the
    // empty/full concurrent read-write rules directly.  A soft reset
    // cycle discards both operations.
    assign wr_fire = write_enb && !full  && !soft_reset;
    assign rd_fire = read_enb  && !empty && !soft_reset;

    router_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ({lfd_state, data_in}),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_q)
    );

    // A header read reloads the counter from its length field; any other
    // read counts down until the parity byte brings it to zero.
    always_comb begin
        count_cur = count_q;
        if (rd_pending) begin
            if (rd_q[WIDTH]) begin
                count_cur = CNT_W'(header_count(rd_q[LEN_MSB:LEN_LSB]));
            end else if (count_q != '0) begin
                count_cur = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_pending <= 1'b0;
            show_data  <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_pending <= 1'b0;
            show_data  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q    <= count_cur;
            rd_pending <= rd_fire;
            // Between packets the bus goes idle; mid-packet it holds the
            // last byte while the reader stalls.
            if (rd_fire) begin
                show_data <= 1'b1;
            end else if (count_cur == '0) begin
                show_data <= 1'b0;
            end
        end
    end

    assign data_out = show_data ? rd_q[WIDTH-1:0] : WIDTH'(IDLE_DATA);

endmodule

// File: tb/tb_router_fifo.sv
// ---------------------------------------------------------------------------
// tb_router_fifo
//
// Directed scoreboard bench for router_fifo.  The stimulus process pushes
// the byte it expects for every read it issues; a monitor process detects
// each accepted read and compares data_out one cycle later.
// ---------------------------------------------------------------------------
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int         check_count = 0;
    int         pass_count  = 0;
    logic [7:0] exp_q[$];

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and return just after the sampling edge.
    task automatic applyStimulus(input logic wr, input logic lfd,
                                 input logic [7:0] din, input logic rd);
        write_enb = wr;
        lfd_state = lfd;
        data_in   = din;
        read_enb  = rd;
        @(posedge clock);
        #1;
        write_enb = 1'b0;
        lfd_state = 1'b0;
        data_in   = 8'h00;
        read_enb  = 1'b0;
    endtask

    task automatic writeByte(input logic lfd, input logic [7:0] din);
        applyStimulus(1'b1, lfd, din, 1'b0);
    endtask

    task automatic readExpect(input logic [7:0] expected);
        exp_q.push_back(expected);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: an accepted read is decided by the inputs and flags seen
    // before the edge; the data appears after that edge.
    initial begin
        logic       pending;
        logic [7:0] expected;
        pending = 1'b0;
        forever begin
            @(negedge clock);
            if (pending) begin
                if (exp_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL unexpected_read: got %02h, expected no read", data_out);
                end else begin
                    expected = exp_q.pop_front();
                    checkOutput("read_data", data_out, expected);
                end
            end
            pending = resetn && !soft_reset && read_enb && !empty;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;
        #12;
        checkOutput("por_empty", {7'b0, empty}, 8'h01);
        checkOutput("por_full", {7'b0, full}, 8'h00);
        checkOutput("por_data", data_out, 8'h00);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // ---- Asynchronous reset with no clock edge ----
        writeByte(1'b1, 8'h3C);
        writeByte(1'b0, 8'h11);
        readExpect(8'h3C);
        idleCycle();
        checkOutput("pre_rst_data", data_out, 8'h3C);
        checkOutput("pre_rst_empty", {7'b0, empty}, 8'h00);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_rst_empty", {7'b0, empty}, 8'h01);
        checkOutput("async_rst_full", {7'b0, full}, 8'h00);
        checkOutput("async_rst_data", data_out, 8'h00);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // ---- One packet: len 3, dest 1, three payload bytes, parity ----
        writeByte(1'b1, 8'h0D);
        writeByte(1'b0, 8'hA1);
        writeByte(1'b0, 8'hA2);
        writeByte(1'b0, 8'hA3);
        writeByte(1'b0, 8'h5F);
        readExpect(8'h0D);
        readExpect(8'hA1);
        readExpect(8'hA2);
        readExpect(8'hA3);
        readExpect(8'h5F);
        idleCycle();
        checkOutput("pkt_idle_data", data_out, 8'h00);
        checkOutput("pkt_idle_empty", {7'b0, empty}, 8'h01);

        // ---- Full boundary, dropped write, read while empty ----
        for (int i = 0; i < 16; i++) begin
            writeByte(1'b1, 8'(i));
        end
        checkOutput("fill_full", {7'b0, full}, 8'h01);
        writeByte(1'b1, 8'hFF);
        checkOutput("drop_full", {7'b0, full}, 8'h01);
        for (int i = 0; i < 16; i++) begin
            readExpect(8'(i));
        end
        idleCycle();
        checkOutput("drain_empty", {7'b0, empty}, 8'h01);
        // Last byte 0x0F read as a header leaves count=4, so the bus holds.
        checkOutput("drain_hold", data_out, 8'h0F);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rd_empty_hold", data_out, 8'h0F);

        // ---- Concurrent read/write across the pointer wrap ----
        for (int k = 0; k < 8; k++) begin
            writeByte(1'b0, 8'(8'h40 + k));
        end
        for (int j = 0; j < 20; j++) begin
            exp_q.push_back(8'(8'h40 + j));
            applyStimulus(1'b1, 1'b0, 8'(8'h48 + j), 1'b1);
            checkOutput("rw_full", {7'b0, full}, 8'h00);
            checkOutput("rw_empty", {7'b0, empty}, 8'h00);
        end
        for (int k = 20; k < 28; k++) begin
            readExpect(8'(8'h40 + k));
        end
        idleCycle();
        checkOutput("rw_end_empty", {7'b0, empty}, 8'h01);
        checkOutput("rw_end_data", data_out, 8'h00);

        // ---- soft_reset mid-packet ----
        writeByte(1'b1, 8'h09);
        for (int k = 0; k < 6; k++) begin
            writeByte(1'b0, 8'(8'h71 + k));
        end
        readExpect(8'h09);
        idleCycle();
        checkOutput("sr_pre_empty", {7'b0, empty}, 8'h00);
        checkOutput("sr_pre_data", data_out, 8'h09);
        soft_reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1);
        soft_reset = 1'b0;
        checkOutput("sr_empty", {7'b0, empty}, 8'h01);
        checkOutput("sr_full", {7'b0, full}, 8'h00);
        checkOutput("sr_data", data_out, 8'h00);
        idleCycle();
        checkOutput("sr_idle_data", data_out, 8'h00);
        writeByte(1'b1, 8'h05);
        writeByte(1'b0, 8'hB1);
        writeByte(1'b0, 8'hB4);
        readExpect(8'h05);
        readExpect(8'hB1);
        readExpect(8'hB4);
        idleCycle();
        checkOutput("sr_pkt_data", data_out, 8'h00);
        checkOutput("sr_pkt_empty", {7'b0, empty}, 8'h01);

        // ---- Zero-length header: count goes 1 then 0 ----
        writeByte(1'b1, 8'h01);
        writeByte(1'b0, 8'hC3);
        readExpect(8'h01);
        idleCycle();
        checkOutput("len0_hold", data_out, 8'h01);
        readExpect(8'hC3);
        idleCycle();
        checkOutput("len0_idle", data_out, 8'h00);

        // ---- Write while full with concurrent read ----
        for (int i = 0; i < 16; i++) begin
            writeByte(1'b0, 8'(8'h80 + i));
        end
        checkOutput("wf_full", {7'b0, full}, 8'h01);
        exp_q.push_back(8'h80);
        applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1);
        checkOutput("wf_not_full", {7'b0, full}, 8'h00);
        checkOutput("wf_not_empty", {7'b0, empty}, 8'h00);
        for (int i = 1; i < 16; i++) begin
            readExpect(8'(8'h80 + i));
        end
        idleCycle();
        checkOutput("wf_drained", {7'b0, empty}, 8'h01);
        checkOutput("wf_idle_data", data_out, 8'h00);

        idleCycle();
        checkOutput("scoreboard_left", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
